// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - MIPS R/I/J instruction word assembler with address-tagged output FIFO
module instr_assembler #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_fmt,
    input  logic [5:0]               in_opcode,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_shamt,
    input  logic [5:0]               in_funct,
    input  logic [15:0]              in_imm16,
    input  logic [25:0]              in_imm26,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   addr_mem  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   addr_ctr;
    logic [31:0]   enc_word;
    logic          accept;
    logic          illegal;
    logic          push;
    logic          pop;

    // Ready depends only on occupancy, so a pop never opens a slot in the same cycle.
    assign in_ready  = (count != CW'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign illegal   = (in_fmt == 2'd3);
    assign push      = accept & ~illegal & ~flush;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready & ~flush;

    // Pack the fields selected by the format; unused fields are dropped.
    always_comb begin
        enc_word = '0;
        case (in_fmt)
            2'd0:    enc_word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
            2'd1:    enc_word = {in_opcode, in_rs, in_rt, in_imm16};
            2'd2:    enc_word = {in_opcode, in_imm26};
            default: enc_word = '0;
        endcase
    end

    // Storage array; contents are only observable through the count-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= enc_word;
            addr_mem[wr_ptr]  <= addr_ctr;
        end
    end

    // Pointers, occupancy, address counter and error pulse; flush overrides everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_ctr <= BASE_ADDR;
            err      <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_ctr <= BASE_ADDR;
            err      <= 1'b0;
        end else begin
            err <= accept & illegal;
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                addr_ctr <= addr_ctr + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head of queue reads as zero whenever the FIFO is empty.
    always_comb begin
        out_instr = '0;
        out_addr  = '0;
        if (out_valid) begin
            out_instr = instr_mem[rd_ptr];
            out_addr  = addr_mem[rd_ptr];
        end
    end
endmodule
